// File: rtl/rgb2ycbcr_pipe_if.sv
// rgb2ycbcr_pipe_if: pixel stream bundle for the RGB to YCbCr converter.
// Input side:  in_valid/in_ready handshake, r/g/b components, in_last flag.
// Output side: out_valid/out_ready handshake, y/cb/cr components, out_last flag.
// slave is the converter's view; master is the source/sink view.
interface rgb2ycbcr_pipe_if;
    logic       in_valid, in_ready, in_last;
    logic       out_valid, out_ready, out_last;
    logic [7:0] r, g, b;
    logic [7:0] y, cb, cr;
    modport slave (
        input  in_valid, r, g, b, in_last, out_ready,
        output in_ready, out_valid, y, cb, cr, out_last
    );
    modport master (
        output in_valid, r, g, b, in_last, out_ready,
        input  in_ready, out_valid, y, cb, cr, out_last
    );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// rgb2ycbcr_pipe: 3-stage flow-controlled 8-bit RGB to full-range BT.601 YCbCr.
// clock : rising-edge system clock
// reset : synchronous active-high reset, empties the pipeline
// px    : slave side of the pixel stream (RGB in, YCbCr out, last passed through)
module rgb2ycbcr_pipe (
    input  logic clock,
    input  logic reset,
    rgb2ycbcr_pipe_if.slave px
);
    logic               advance;
    logic signed [17:0] rs, gs, bs;
    logic signed [17:0] p_d [9];
    logic signed [17:0] p_q [9];
    logic signed [17:0] s_d [3];
    logic signed [17:0] s_q [3];
    logic               v1_q, v2_q, v3_q, l1_q, l2_q, l3_q;
    logic [7:0]         y_d, cb_d, cr_d, y_q, cb_q, cr_q;

    function automatic logic [7:0] sat(input logic signed [17:0] v);
        return v < 18'sd0 ? 8'd0 : v > 18'sd255 ? 8'd255 : v[7:0];
    endfunction

    // One global enable: the whole pipe moves whenever the output slot is free or draining.
    always_comb begin
        advance = !v3_q || px.out_ready;
        rs = {10'd0, px.r};
        gs = {10'd0, px.g};
        bs = {10'd0, px.b};
        p_d[0] = rs * 18'sd77;
        p_d[1] = gs * 18'sd150;
        p_d[2] = bs * 18'sd29;
        p_d[3] = rs * (-18'sd43);
        p_d[4] = gs * (-18'sd85);
        p_d[5] = bs * 18'sd128;
        p_d[6] = rs * 18'sd128;
        p_d[7] = gs * (-18'sd107);
        p_d[8] = bs * (-18'sd21);
        s_d[0] = p_q[0] + p_q[1] + p_q[2] + 18'sd128;
        s_d[1] = p_q[3] + p_q[4] + p_q[5] + 18'sd128;
        s_d[2] = p_q[6] + p_q[7] + p_q[8] + 18'sd128;
        // Arithmetic shift floors negative chroma sums before the offset.
        y_d  = sat(s_q[0] >>> 8);
        cb_d = sat((s_q[1] >>> 8) + 18'sd128);
        cr_d = sat((s_q[2] >>> 8) + 18'sd128);
    end

    // Datapath registers carry no reset; only valids and visible outputs are cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            l1_q <= 1'b0;
            l2_q <= 1'b0;
            l3_q <= 1'b0;
            y_q  <= 8'd0;
            cb_q <= 8'd0;
            cr_q <= 8'd0;
        end else if (advance) begin
            v1_q <= px.in_valid;
            l1_q <= px.in_last;
            p_q  <= p_d;
            v2_q <= v1_q;
            l2_q <= l1_q;
            s_q  <= s_d;
            v3_q <= v2_q;
            l3_q <= l2_q;
            y_q  <= y_d;
            cb_q <= cb_d;
            cr_q <= cr_d;
        end
    end

    assign px.in_ready  = advance;
    assign px.out_valid = v3_q;
    assign px.out_last  = l3_q;
    assign px.y         = y_q;
    assign px.cb        = cb_q;
    assign px.cr        = cr_q;
endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// tb_rgb2ycbcr_pipe: directed and random checks of rgb2ycbcr_pipe.
module tb_rgb2ycbcr_pipe;
    typedef struct packed {
        logic [23:0] d;
        logic        l;
        int          c;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   n = 0;
    bit   lat = 1'b0;
    exp_t q[$];

    rgb2ycbcr_pipe_if px ();
    rgb2ycbcr_pipe dut (.clock(clock), .reset(reset), .px(px));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] clamp(input int v);
        return v < 0 ? 8'd0 : v > 255 ? 8'd255 : v[7:0];
    endfunction

    function automatic logic [23:0] model(input int r, input int g, input int b);
        return {clamp((77 * r + 150 * g + 29 * b + 128) >>> 8),
                clamp(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128),
                clamp(((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128)};
    endfunction

    // One clock: drive at negedge, settle, log both transfers that the next posedge performs.
    task automatic cyc(input logic iv, input logic [7:0] ir, input logic [7:0] ig, input logic [7:0] ib,
                       input logic il, input logic [23:0] e, input logic ordy, output logic acc);
        exp_t x;
        @(negedge clock);
        px.in_valid  = iv;
        px.r         = ir;
        px.g         = ig;
        px.b         = ib;
        px.in_last   = il;
        px.out_ready = ordy;
        #1;
        acc = iv && px.in_ready;
        if (px.out_valid && px.out_ready) begin
            chk("out_expected", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                x = q.pop_front();
                chk("pixel", {7'd0, px.y, px.cb, px.cr, px.out_last}, {7'd0, x.d, x.l});
                if (lat) chk("latency", n - x.c, 32'd3);
            end
        end
        if (acc) begin
            x.d = e;
            x.l = il;
            x.c = n;
            q.push_back(x);
        end
        n++;
    endtask

    task automatic drain(input string tag);
        logic a;
        for (int k = 0; k < 30 && q.size() != 0; k++) cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 24'd0, 1'b1, a);
        chk(tag, q.size(), 32'd0);
    endtask

    initial begin
        logic       a;
        logic [7:0] sy, scb, scr, rr, gg, bb;
        logic       sl, ll;
        int         sent;
        reset = 1'b1;
        px.in_valid = 1'b0;
        px.r = 8'd0;
        px.g = 8'd0;
        px.b = 8'd0;
        px.in_last = 1'b0;
        px.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", {31'd0, px.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, px.in_ready}, 32'd1);
        chk("rst_data", {7'd0, px.y, px.cb, px.cr, px.out_last}, 32'd0);
        reset = 1'b0;

        lat = 1'b1;
        cyc(1'b1, 8'd0, 8'd0, 8'd0, 1'b0, {8'd0, 8'd128, 8'd128}, 1'b1, a);
        chk("colour_acc", {31'd0, a}, 32'd1);
        cyc(1'b1, 8'd255, 8'd255, 8'd255, 1'b0, {8'd255, 8'd128, 8'd128}, 1'b1, a);
        cyc(1'b1, 8'd255, 8'd0, 8'd0, 1'b0, {8'd77, 8'd85, 8'd255}, 1'b1, a);
        cyc(1'b1, 8'd0, 8'd0, 8'd255, 1'b0, {8'd29, 8'd255, 8'd107}, 1'b1, a);
        cyc(1'b1, 8'd0, 8'd255, 8'd0, 1'b0, {8'd149, 8'd43, 8'd21}, 1'b1, a);
        cyc(1'b1, 8'd255, 8'd0, 8'd255, 1'b1, {8'd106, 8'd213, 8'd235}, 1'b1, a);
        drain("colour_drain");

        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 8'(i), 8'(i), 8'(i), i == 255, {8'(i), 16'h8080}, 1'b1, a);
            chk("stream_acc", {31'd0, a}, 32'd1);
        end
        drain("stream_drain");

        lat = 1'b0;
        for (int k = 0; k < 4; k++) cyc(1'b1, 8'(20 * (k + 1)), 8'(20 * (k + 1)), 8'(20 * (k + 1)), 1'b0,
                                         {8'(20 * (k + 1)), 16'h8080}, 1'b1, a);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 8'd200, 8'd200, 8'd200, 1'b0, {8'd200, 16'h8080}, 1'b0, a);
            if (k == 0) {sy, scb, scr, sl} = {px.y, px.cb, px.cr, px.out_last};
            chk("bp_in_ready", {31'd0, px.in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, px.out_valid}, 32'd1);
            chk("bp_stable", {7'd0, px.y, px.cb, px.cr, px.out_last}, {7'd0, sy, scb, scr, sl});
            chk("bp_acc", {31'd0, a}, 32'd0);
        end
        for (int k = 0; k < 10 && !a; k++) cyc(1'b1, 8'd200, 8'd200, 8'd200, 1'b0, {8'd200, 16'h8080}, 1'b1, a);
        chk("bp_resume", {31'd0, a}, 32'd1);
        drain("bp_drain");

        lat = 1'b1;
        cyc(1'b1, 8'd50, 8'd50, 8'd50, 1'b0, {8'd50, 16'h8080}, 1'b1, a);
        cyc(1'b1, 8'd60, 8'd60, 8'd60, 1'b1, {8'd60, 16'h8080}, 1'b1, a);
        cyc(1'b1, 8'd70, 8'd70, 8'd70, 1'b0, {8'd70, 16'h8080}, 1'b1, a);
        @(negedge clock);
        reset = 1'b1;
        px.in_valid = 1'b0;
        @(negedge clock);
        chk("mid_rst_valid", {31'd0, px.out_valid}, 32'd0);
        chk("mid_rst_data", {7'd0, px.y, px.cb, px.cr, px.out_last}, 32'd0);
        reset = 1'b0;
        q.delete();
        cyc(1'b1, 8'd99, 8'd99, 8'd99, 1'b0, {8'd99, 16'h8080}, 1'b1, a);
        drain("post_rst_drain");

        lat = 1'b0;
        sent = 0;
        rr = 8'($urandom);
        gg = 8'($urandom);
        bb = 8'($urandom);
        ll = 1'($urandom);
        for (int k = 0; k < 60000 && sent < 10000; k++) begin
            cyc($urandom_range(0, 9) < 7, rr, gg, bb, ll, model(rr, gg, bb), $urandom_range(0, 9) < 7, a);
            if (a) begin
                sent++;
                rr = 8'($urandom);
                gg = 8'($urandom);
                bb = 8'($urandom);
                ll = 1'($urandom);
            end
        end
        chk("rand_sent", sent, 32'd10000);
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
